serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- Deserializer that consumes the 32-bit serial stream produced by the team's serial transmitter stage.
- Inputs are the transmitter's serial data, its frame signal (busy) and its bit clock.
- Samples each bit mid-cell (bit-clock falling edge), assembles MSB-first words and presents them in parallel with a valid/read handshake.
- Sits directly downstream of the transmitter, in the Clk domain; the bit clock is treated as asynchronous data.

Parameters:
- DATA_WIDTH, 32, bits per frame and width of DataOut.
- SYNC_STAGES, 2, synchronizer flops on SerialClk, SerialIn and SerialFrame (minimum 2).

Ports:
- Clk, input, 1, system clock; all logic on posedge.
- Reset, input, 1, synchronous, active-high.
- SerialClk, input, 1, transmitter bit clock (asynchronous).
- SerialIn, input, 1, serial data; MSB first, changes on SerialClk rising edge.
- SerialFrame, input, 1, high while a frame is on the line (transmitter busy).
- DataRead, input, 1, one-Clk pulse; consumer takes DataOut.
- ErrClear, input, 1, one-Clk pulse; clears the sticky error flags.
- DataOut, output, DATA_WIDTH, last complete word.
- DataValid, output, 1, high while DataOut holds an unread word.
- RxBusy, output, 1, high in RECEIVE and WAIT_END.
- FrameError, output, 1, sticky; frame length was not DATA_WIDTH.
- Overrun, output, 1, sticky; a word completed while DataValid was still 1.

Behaviour:
- Reset (sampled on Clk posedge):
  - DataOut=0, DataValid=0, RxBusy=0, FrameError=0, Overrun=0.
  - Shift register=0, bit counter=0, state=IDLE.
  - All synchronizer and edge-detect flops cleared to 0.
  - Reset asserted mid-frame aborts the frame. The partial word is lost and no flag is set.
  - After reset, a frame already in progress (SerialFrame high) is ignored until SerialFrame is seen low and then rises again.
- Synchronization:
  - SerialClk, SerialIn and SerialFrame each pass through SYNC_STAGES flops.
  - Edge detection uses one further delayed copy of the synced SerialClk and SerialFrame.
  - Clk must be at least 4x SerialClk.
- Bit sample: asserted in the Clk cycle where synced SerialClk is 0 and its delayed copy is 1 (falling edge). The synced SerialIn is captured in that same cycle.
- States:
  - IDLE: on synced SerialFrame rising edge, go to RECEIVE with count=0.
  - RECEIVE: each bit sample does shift <= {shift[DATA_WIDTH-2:0], SerialIn_s} and count+1.
    - On the sample that makes count==DATA_WIDTH: DataOut <= assembled word on the next Clk edge, DataValid=1, go to WAIT_END.
    - If synced SerialFrame goes low before count==DATA_WIDTH (including count=0): FrameError=1, discard the word, go to IDLE. DataOut and DataValid are unchanged.
  - WAIT_END:
    - A further bit sample while SerialFrame is still high sets FrameError=1. The delivered word stands and extra bits are ignored.
    - When SerialFrame goes low, go to IDLE.
- Latency: DataValid rises exactly 1 Clk after the Clk in which the last bit is sampled.
- Handshake:
  - DataRead while DataValid=1 clears DataValid on the next edge.
  - DataRead while DataValid=0 has no effect.
  - DataOut holds its value after it is read.
- Overrun: word completion while DataValid=1 and DataRead not asserted in the same cycle sets Overrun=1. The new word overwrites DataOut and DataValid stays 1.
- Simultaneous completion and DataRead: the new word is loaded, DataValid stays 1, and Overrun is not set.
- Error flags: FrameError and Overrun clear only on ErrClear or Reset. A set event in the same cycle as ErrClear wins (the flag ends at 1).
- RxBusy: combinational decode of state (RECEIVE or WAIT_END).

Test Plan:
- Single frame: transmit 0xA5C3_0F1E (32 SerialClk periods, Clk = 8x SerialClk) -> DataOut=0xA5C30F1E and DataValid=1 one Clk after the 32nd sample. RxBusy drops after SerialFrame falls. No flags set.
- Back-to-back frames: send 0x0000_0001 then 0xFFFF_FFFE, with DataRead pulsed between them -> both words delivered in order and Overrun=0. Then send 0x1234_5678 with no DataRead before it completes -> Overrun=1, DataOut=0x12345678.
- Short frame: drop SerialFrame after 20 bits -> FrameError=1, DataValid unchanged (stays 0 from reset), state returns to IDLE. A following full frame of 0xDEADBEEF is received correctly, with FrameError still 1 until ErrClear is pulsed.
- Long frame: hold SerialFrame for 33 bit clocks -> the first 32 bits are delivered as the word, and FrameError=1.
- Reset mid-frame: assert Reset after 10 bits, then release while SerialFrame is still high -> all outputs are 0 and that frame is ignored. The next full frame of 0xCAFEF00D is received correctly.
- Simultaneous events: pulse DataRead in the exact completion cycle with DataValid=1 -> DataValid stays 1 and Overrun=0. Pulse ErrClear in the same cycle as a FrameError event -> FrameError=1.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver: deserializes the transmitter's MSB-first serial stream
// into parallel words. Each bit is sampled on the falling edge of the bit
// clock, after resynchronizing that clock into the Clk domain. Words are
// presented on a valid/read handshake. Sticky flags report frame-length
// errors and overruns.
module serial_receiver #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SerialClk,
  input  logic                  SerialIn,
  input  logic                  SerialFrame,
  input  logic                  DataRead,
  input  logic                  ErrClear,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  RxBusy,
  output logic                  FrameError,
  output logic                  Overrun
);

  localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_inSync;
  logic [SYNC_STAGES-1:0] r_frameSync;
  logic                   r_clkDly;
  logic                   r_frameDly;
  logic [SETTLE_W-1:0]    r_settle;
  logic                   r_armed;

  state_t                 r_state;
  logic [DATA_WIDTH-2:0]  r_shift;
  logic [CNT_W-1:0]       r_count;
  logic [DATA_WIDTH-1:0]  r_dataOut;
  logic                   r_dataValid;
  logic                   r_frameError;
  logic                   r_overrun;

  logic                   w_clkS;
  logic                   w_inS;
  logic                   w_frameS;
  logic                   w_sample;
  logic                   w_frameRise;
  logic [DATA_WIDTH-1:0]  w_nextShift;
  logic                   w_complete;
  logic                   w_frameErrEvt;
  logic                   w_overrunEvt;

  assign w_clkS   = r_clkSync[SYNC_STAGES-1];
  assign w_inS    = r_inSync[SYNC_STAGES-1];
  assign w_frameS = r_frameSync[SYNC_STAGES-1];

  // Bit clock falling edge marks mid-cell; frame rising edge opens a frame.
  assign w_sample    = ~w_clkS & r_clkDly;
  assign w_frameRise = w_frameS & ~r_frameDly;

  // Only DATA_WIDTH-1 bits are stored; the final bit comes straight from the
  // synchronizer when the word is completed.
  assign w_nextShift = {r_shift, w_inS};

  assign w_complete = (r_state == RECEIVE) && w_sample && (r_count == LAST_BIT);

  // Frame ended early, or a bit arrived after the word was already complete.
  assign w_frameErrEvt = ((r_state == RECEIVE) && !w_complete && !w_frameS) ||
                         ((r_state == WAIT_END) && w_frameS && w_sample);

  assign w_overrunEvt = w_complete && r_dataValid && !DataRead;

  assign DataOut    = r_dataOut;
  assign DataValid  = r_dataValid;
  assign FrameError = r_frameError;
  assign Overrun    = r_overrun;
  assign RxBusy     = (r_state == RECEIVE) || (r_state == WAIT_END);

  // Synchronizer chains for the asynchronous serial inputs, plus one delayed copy for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clkSync   <= '0;
      r_inSync    <= '0;
      r_frameSync <= '0;
      r_clkDly    <= 1'b0;
      r_frameDly  <= 1'b0;
    end else begin
      r_clkSync   <= {r_clkSync[SYNC_STAGES-2:0], SerialClk};
      r_inSync    <= {r_inSync[SYNC_STAGES-2:0], SerialIn};
      r_frameSync <= {r_frameSync[SYNC_STAGES-2:0], SerialFrame};
      r_clkDly    <= w_clkS;
      r_frameDly  <= w_frameS;
    end
  end

  // After reset, wait until the synchronizers hold real data and the frame is seen low before accepting a frame start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SETTLE_DONE) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end
      if ((r_settle == SETTLE_DONE) && !w_frameS) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Receive state machine with word assembly, the output handshake and the sticky error flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_count      <= '0;
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_frameError <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frameError <= (r_frameError & ~ErrClear) | w_frameErrEvt;
      r_overrun    <= (r_overrun & ~ErrClear) | w_overrunEvt;

      if (w_complete) begin
        r_dataOut   <= w_nextShift;
        r_dataValid <= 1'b1;
      end else if (DataRead) begin
        r_dataValid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_frameRise && r_armed) begin
            r_state <= RECEIVE;
            r_count <= '0;
            r_shift <= '0;
          end
        end
        RECEIVE: begin
          if (w_complete) begin
            r_shift <= w_nextShift[DATA_WIDTH-2:0];
            r_count <= r_count + CNT_W'(1);
            r_state <= WAIT_END;
          end else if (!w_frameS) begin
            r_state <= IDLE;
          end else if (w_sample) begin
            r_shift <= w_nextShift[DATA_WIDTH-2:0];
            r_count <= r_count + CNT_W'(1);
          end
        end
        WAIT_END: begin
          if (!w_frameS) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frames into serial_receiver. The stimulus
// pushes expected words into a queue, and a monitor pops and compares them
// whenever a new word is presented.
module tb_serial_receiver;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        SerialClk;
  logic        SerialIn;
  logic        SerialFrame;
  logic        DataRead;
  logic        ErrClear;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        RxBusy;
  logic        FrameError;
  logic        Overrun;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] expQ[$];
  logic        prevValid = 1'b0;
  logic [31:0] prevOut = '0;

  serial_receiver #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .SerialClk  (SerialClk),
    .SerialIn   (SerialIn),
    .SerialFrame(SerialFrame),
    .DataRead   (DataRead),
    .ErrClear   (ErrClear),
    .DataOut    (DataOut),
    .DataValid  (DataValid),
    .RxBusy     (RxBusy),
    .FrameError (FrameError),
    .Overrun    (Overrun)
  );

  // System clock, 10 ns period; the bit clock is 8x slower.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every newly presented word is popped from the queue and compared.
  always @(negedge Clk) begin
    logic [31:0] expWord;
    if (Reset !== 1'b1) begin
      if (DataValid === 1'b1 && (prevValid !== 1'b1 || DataOut !== prevOut)) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpectedWord got %h expected none", DataOut);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("deliveredWord", DataOut, expWord);
        end
      end
    end
    prevValid = DataValid;
    prevOut   = DataOut;
  end

  // Sends one frame of nbits bits, driven on Clk negedges (4 Clk per half bit).
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input bit expectWord,
                               input bit readAtDone, input bit checkLatency,
                               input int resetAfter, input bit clearAtEnd);
    if (expectWord) expQ.push_back(word);
    SerialFrame = 1'b1;
    repeat (4) @(negedge Clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == resetAfter) begin
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        checkOutput("midResetDataOut", DataOut, 32'h0);
        checkOutput("midResetValid", {31'b0, DataValid}, 32'h0);
        checkOutput("midResetBusy", {31'b0, RxBusy}, 32'h0);
        checkOutput("midResetFrameErr", {31'b0, FrameError}, 32'h0);
        checkOutput("midResetOverrun", {31'b0, Overrun}, 32'h0);
      end
      SerialIn  = (i < 32) ? word[31-i] : 1'b0;
      SerialClk = 1'b1;
      repeat (4) @(negedge Clk);
      if (checkLatency && i == 16) checkOutput("busyMidFrame", {31'b0, RxBusy}, 32'h1);
      SerialClk = 1'b0;
      if (i == 31 && (checkLatency || readAtDone)) begin
        repeat (2) @(negedge Clk);
        if (checkLatency) checkOutput("validBeforeDone", {31'b0, DataValid}, 32'h0);
        if (readAtDone) DataRead = 1'b1;
        @(negedge Clk);
        DataRead = 1'b0;
        if (checkLatency) checkOutput("validOneClkAfter", {31'b0, DataValid}, 32'h1);
        if (readAtDone) checkOutput("validHeldOnReadAtDone", {31'b0, DataValid}, 32'h1);
        @(negedge Clk);
      end else begin
        repeat (4) @(negedge Clk);
      end
    end
    SerialFrame = 1'b0;
    if (clearAtEnd) begin
      repeat (2) @(negedge Clk);
      ErrClear = 1'b1;
      @(negedge Clk);
      ErrClear = 1'b0;
      repeat (5) @(negedge Clk);
    end else begin
      repeat (8) @(negedge Clk);
    end
  endtask

  task automatic readPulse();
    DataRead = 1'b1;
    @(negedge Clk);
    DataRead = 1'b0;
    @(negedge Clk);
  endtask

  task automatic clearPulse();
    ErrClear = 1'b1;
    @(negedge Clk);
    ErrClear = 1'b0;
    @(negedge Clk);
  endtask

  // Directed test sequence.
  initial begin
    Reset       = 1'b1;
    SerialClk   = 1'b0;
    SerialIn    = 1'b0;
    SerialFrame = 1'b0;
    DataRead    = 1'b0;
    ErrClear    = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkOutput("resetDataOut", DataOut, 32'h0);
    checkOutput("resetValid", {31'b0, DataValid}, 32'h0);
    checkOutput("resetBusy", {31'b0, RxBusy}, 32'h0);
    checkOutput("resetFrameErr", {31'b0, FrameError}, 32'h0);
    checkOutput("resetOverrun", {31'b0, Overrun}, 32'h0);
    repeat (6) @(negedge Clk);

    $display("[TB] single frame");
    applyStimulus(32'hA5C3_0F1E, 32, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    checkOutput("singleBusyAfter", {31'b0, RxBusy}, 32'h0);
    checkOutput("singleFrameErr", {31'b0, FrameError}, 32'h0);
    checkOutput("singleOverrun", {31'b0, Overrun}, 32'h0);
    readPulse();
    checkOutput("readClearsValid", {31'b0, DataValid}, 32'h0);
    checkOutput("readHoldsData", DataOut, 32'hA5C3_0F1E);

    $display("[TB] back-to-back frames");
    applyStimulus(32'h0000_0001, 32, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    readPulse();
    applyStimulus(32'hFFFF_FFFE, 32, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("b2bNoOverrun", {31'b0, Overrun}, 32'h0);
    applyStimulus(32'h1234_5678, 32, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("overrunSet", {31'b0, Overrun}, 32'h1);
    checkOutput("overrunData", DataOut, 32'h1234_5678);
    checkOutput("overrunValid", {31'b0, DataValid}, 32'h1);
    clearPulse();
    checkOutput("overrunCleared", {31'b0, Overrun}, 32'h0);
    readPulse();

    $display("[TB] short frame");
    applyStimulus(32'hFACE_B00C, 20, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("shortFrameErr", {31'b0, FrameError}, 32'h1);
    checkOutput("shortValid", {31'b0, DataValid}, 32'h0);
    checkOutput("shortBusy", {31'b0, RxBusy}, 32'h0);
    applyStimulus(32'hDEAD_BEEF, 32, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("frameErrSticky", {31'b0, FrameError}, 32'h1);
    checkOutput("afterShortData", DataOut, 32'hDEAD_BEEF);
    clearPulse();
    checkOutput("frameErrCleared", {31'b0, FrameError}, 32'h0);
    readPulse();

    $display("[TB] long frame");
    applyStimulus(32'h8765_4321, 33, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("longFrameErr", {31'b0, FrameError}, 32'h1);
    checkOutput("longData", DataOut, 32'h8765_4321);
    clearPulse();
    readPulse();

    $display("[TB] reset mid-frame");
    applyStimulus(32'h55AA_55AA, 32, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    checkOutput("ignoredFrameValid", {31'b0, DataValid}, 32'h0);
    checkOutput("ignoredFrameErr", {31'b0, FrameError}, 32'h0);
    applyStimulus(32'hCAFE_F00D, 32, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("afterResetData", DataOut, 32'hCAFE_F00D);

    $display("[TB] simultaneous events");
    applyStimulus(32'h1357_9BDF, 32, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    checkOutput("readAtDoneNoOverrun", {31'b0, Overrun}, 32'h0);
    checkOutput("readAtDoneData", DataOut, 32'h1357_9BDF);
    readPulse();
    applyStimulus(32'h0F0F_0F0F, 12, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    checkOutput("setWinsOverClear", {31'b0, FrameError}, 32'h1);
    clearPulse();
    checkOutput("finalClear", {31'b0, FrameError}, 32'h0);

    checkOutput("queueDrained", expQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
